// File: rtl/hba_qei.sv
// Dual quadrature encoder interface on the HBA bus: synchronizes two A/B pairs,
// decodes Gray-code steps into signed 16-bit counts and exposes them as registers.
module hba_qei #(
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int PERIPH_ADDR       = 0
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset_n,
  input  logic                  hba_rnw,
  input  logic                  hba_select,
  input  logic [ADDR_WIDTH-1:0] hba_abus,
  input  logic [DBUS_WIDTH-1:0] hba_dbus,
  output logic [DBUS_WIDTH-1:0] hba_dbus_slave,
  output logic                  hba_xferack_slave,
  output logic                  slave_interrupt,
  input  logic [1:0]            encoder_a,
  input  logic [1:0]            encoder_b
);

  localparam logic [REG_ADDR_WIDTH-1:0] REG_CTRL     = REG_ADDR_WIDTH'(0);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_LEFT_LO  = REG_ADDR_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_LEFT_HI  = REG_ADDR_WIDTH'(2);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_RIGHT_LO = REG_ADDR_WIDTH'(3);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_RIGHT_HI = REG_ADDR_WIDTH'(4);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ERR      = REG_ADDR_WIDTH'(5);

  // Synchronizers, decoder history and warm-up counter
  logic [1:0]       r_a_s1, r_a_s2, r_b_s1, r_b_s2;
  logic [1:0][1:0]  r_prev;
  logic [1:0]       r_warm;

  // Architectural state
  logic [3:0]       r_ctrl;
  logic [1:0]       r_err;
  logic [1:0][15:0] r_count;
  logic [1:0][7:0]  r_shadow;

  // Bus response
  logic                  r_ack;
  logic [DBUS_WIDTH-1:0] r_rdata;

  logic                      w_match, w_access, w_wr, w_rd, w_live;
  logic [REG_ADDR_WIDTH-1:0] w_reg;
  logic [1:0][1:0]           w_s;
  logic [1:0]                w_fwd, w_rev, w_illegal, w_up, w_dn;
  logic [1:0]                w_clr, w_lo_rd, w_err_w1c;
  logic [DBUS_WIDTH-1:0]     w_rdata;

  // Handshake: an access is taken on an edge where select and the peripheral field
  // match while ack is low; ack (with read data) is then high for exactly one cycle,
  // so a held select is serviced every other cycle.
  assign w_match  = hba_select &&
                    (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));
  assign w_access = w_match && !r_ack;
  assign w_wr     = w_access && !hba_rnw;
  assign w_rd     = w_access && hba_rnw;
  assign w_reg    = hba_abus[REG_ADDR_WIDTH-1:0];

  // The first three cycles after reset only refill the synchronizer and history.
  assign w_live = (r_warm == 2'd3);

  always_comb begin
    w_s       = '0;
    w_fwd     = '0;
    w_rev     = '0;
    w_illegal = '0;
    w_up      = '0;
    w_dn      = '0;
    for (int ch = 0; ch < 2; ch++) begin
      w_s[ch] = {r_a_s2[ch], r_b_s2[ch]};
      case ({r_prev[ch], w_s[ch]})
        4'b0001, 4'b0111, 4'b1110, 4'b1000: w_fwd[ch]     = 1'b1;
        4'b0010, 4'b1011, 4'b1101, 4'b0100: w_rev[ch]     = 1'b1;
        4'b0011, 4'b1100, 4'b0110, 4'b1001: w_illegal[ch] = w_live;
        default: ;
      endcase
      w_up[ch] = w_live && r_ctrl[ch] &&
                 ((w_fwd[ch] && !r_ctrl[2+ch]) || (w_rev[ch] && r_ctrl[2+ch]));
      w_dn[ch] = w_live && r_ctrl[ch] &&
                 ((w_rev[ch] && !r_ctrl[2+ch]) || (w_fwd[ch] && r_ctrl[2+ch]));
    end
  end

  always_comb begin
    w_clr[0]   = w_wr && (w_reg == REG_CTRL) && hba_dbus[4];
    w_clr[1]   = w_wr && (w_reg == REG_CTRL) && hba_dbus[5];
    w_lo_rd[0] = w_rd && (w_reg == REG_LEFT_LO);
    w_lo_rd[1] = w_rd && (w_reg == REG_RIGHT_LO);
    w_err_w1c  = (w_wr && (w_reg == REG_ERR)) ? hba_dbus[1:0] : 2'b00;
  end

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_CTRL:     w_rdata = {4'b0000, r_ctrl};
      REG_LEFT_LO:  w_rdata = r_count[0][7:0];
      REG_LEFT_HI:  w_rdata = r_shadow[0];
      REG_RIGHT_LO: w_rdata = r_count[1][7:0];
      REG_RIGHT_HI: w_rdata = r_shadow[1];
      REG_ERR:      w_rdata = {6'b000000, r_err};
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      r_a_s1 <= '0;
      r_a_s2 <= '0;
      r_b_s1 <= '0;
      r_b_s2 <= '0;
      r_prev <= '0;
      r_warm <= '0;
    end else begin
      r_a_s1 <= encoder_a;
      r_a_s2 <= r_a_s1;
      r_b_s1 <= encoder_b;
      r_b_s2 <= r_b_s1;
      r_prev <= w_s;
      if (!w_live) r_warm <= r_warm + 2'd1;
    end
  end

  // Clear wins over a same-cycle step; a low-byte read samples the pre-step count.
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      r_count  <= '0;
      r_shadow <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (w_clr[ch])     r_count[ch] <= 16'h0000;
        else if (w_up[ch]) r_count[ch] <= r_count[ch] + 16'h0001;
        else if (w_dn[ch]) r_count[ch] <= r_count[ch] - 16'h0001;
        if (w_lo_rd[ch])   r_shadow[ch] <= r_count[ch][15:8];
      end
    end
  end

  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      r_ctrl <= '0;
      r_err  <= '0;
    end else begin
      if (w_wr && (w_reg == REG_CTRL)) r_ctrl <= hba_dbus[3:0];
      r_err <= (r_err & ~w_err_w1c) | w_illegal;
    end
  end

  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_access;
      r_rdata <= w_rd ? w_rdata : '0;
    end
  end

  assign hba_xferack_slave = r_ack;
  assign hba_dbus_slave    = r_rdata;
  assign slave_interrupt   = 1'b0;

endmodule
